lc3_writeback: RTL and testbench

Writeback stage of the LC3 pipeline: the producing end of the writeback_out bus. It owns the 8 × 16-bit general-purpose register file and the 3-bit PSR condition codes. It commits the selected result (ALU, memory or PC path) into the destination register when enabled, and presents source-operand values VSR1/VSR2 plus psr to the decode/execute/controller side. It sits between the execute/memaccess outputs and the writeback_out monitor and responder.

---
 rtl/lc3_writeback.sv | 99 +++++++++
 tb/tb_lc3_writeback.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lc3_writeback.sv
// rtl/lc3_writeback.sv - LC3 writeback stage: register file, PSR codes, result commit
//
// Purpose: selects the stage result (ALU, memory or PC path), commits it into
// the 8 x 16-bit general-purpose register file and updates the {N,Z,P}
// condition codes. Source operands are read combinationally from the
// registered array, so there is no write-through bypass.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   enable_writeback commit enable, sampled at rising clk
//   W_Control        result select: 0 aluout, 1 memout, 2 pcout, 3 reserved
//   aluout/memout/pcout  candidate results
//   dr, sr1, sr2     destination / source register indices
//   VSR1, VSR2       R[sr1], R[sr2]
//   psr              condition codes {N,Z,P}
//   wb_illegal       sticky: a commit was attempted with W_Control = 3
module lc3_writeback #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] memout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [2:0]        dr,
  input  logic [2:0]        sr1,
  input  logic [2:0]        sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr,
  output logic              wb_illegal
);

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [2:0]        psr_q;
  logic [2:0]        psr_d;
  logic              illegal_q;
  logic              illegal_d;
  logic [DATA_W-1:0] dr_in;
  logic              commit;

  // Result mux; the reserved select yields zero but is never committed.
  always_comb begin
    dr_in = '0;
    unique case (W_Control)
      SEL_ALU: dr_in = aluout;
      SEL_MEM: dr_in = memout;
      SEL_PC:  dr_in = pcout;
      default: dr_in = '0;
    endcase
  end

  assign commit = enable_writeback && (W_Control != SEL_RSV);

  // Condition codes derived from the committed value; held otherwise.
  always_comb begin
    psr_d = psr_q;
    if (commit) begin
      if (dr_in[DATA_W-1])     psr_d = 3'b100;
      else if (dr_in == '0)    psr_d = 3'b010;
      else                     psr_d = 3'b001;
    end
  end

  // Sticky until reset: once an illegal select is seen it never clears.
  always_comb begin
    illegal_d = illegal_q;
    if (enable_writeback && (W_Control == SEL_RSV)) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      psr_q     <= 3'b000;
      illegal_q <= 1'b0;
    end else begin
      if (commit) regs_q[dr] <= dr_in;
      psr_q     <= psr_d;
      illegal_q <= illegal_d;
    end
  end

  // Reads see the array as of the last edge: a same-cycle write to sr1/sr2
  // is not forwarded.
  assign VSR1       = regs_q[sr1];
  assign VSR2       = regs_q[sr2];
  assign psr        = psr_q;
  assign wb_illegal = illegal_q;

endmodule

// File: tb/tb_lc3_writeback.sv
// tb/tb_lc3_writeback.sv - scoreboard bench for lc3_writeback
module tb_lc3_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_writeback = 1'b0;
  logic [1:0]  W_Control = 2'd0;
  logic [15:0] aluout = '0;
  logic [15:0] memout = '0;
  logic [15:0] pcout = '0;
  logic [2:0]  dr = '0;
  logic [2:0]  sr1 = '0;
  logic [2:0]  sr2 = '0;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  psr;
  logic        wb_illegal;

  lc3_writeback #(.DATA_W(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .enable_writeback(enable_writeback),
    .W_Control(W_Control), .aluout(aluout), .memout(memout), .pcout(pcout),
    .dr(dr), .sr1(sr1), .sr2(sr2),
    .VSR1(VSR1), .VSR2(VSR2), .psr(psr), .wb_illegal(wb_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [2:0]  p;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (VSR1 !== e.v1 || VSR2 !== e.v2 || psr !== e.p || wb_illegal !== e.ill) begin
        n_fail++;
        $display("FAIL %s: got VSR1=%h VSR2=%h psr=%b ill=%b, want VSR1=%h VSR2=%h psr=%b ill=%b",
                 e.name, VSR1, VSR2, psr, wb_illegal, e.v1, e.v2, e.p, e.ill);
      end
    end
  end

  // One cycle of stimulus; the expectation describes outputs before the
  // edge that samples these inputs.
  task automatic cyc(input logic rst_v, input logic en, input logic [1:0] wc,
                     input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc,
                     input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                     input string nm, input logic [15:0] e1, input logic [15:0] e2,
                     input logic [2:0] ep, input logic ei);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rst_v; enable_writeback = en; W_Control = wc;
    aluout = alu; memout = mem; pcout = pc; dr = d; sr1 = s1; sr2 = s2;
    e.name = nm; e.v1 = e1; e.v2 = e2; e.p = ep; e.ill = ei;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] sweep_val(input int i);
    sweep_val = {4'(i + 1), 4'(i), 8'h5A};
  endfunction

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
          3'($urandom), 3'($urandom), 3'($urandom), "reset_hold", 16'h0, 16'h0, 3'b000, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, "reset_release", 16'h0, 16'h0, 3'b000, 1'b0);

    // Source select and condition codes.
    cyc(1'b1, 1'b1, 2'd0, 16'h8001, 16'h0, 16'h0, 3'd2, 3'd2, 3'd0, "pre_alu", 16'h0, 16'h0, 3'b000, 1'b0);
    cyc(1'b1, 1'b1, 2'd1, 16'h0, 16'h0000, 16'h0, 3'd5, 3'd2, 3'd5, "alu_neg", 16'h8001, 16'h0, 3'b100, 1'b0);
    cyc(1'b1, 1'b1, 2'd2, 16'h0, 16'h0, 16'h3005, 3'd7, 3'd5, 3'd2, "mem_zero", 16'h0, 16'h8001, 3'b010, 1'b0);
    cyc(1'b1, 1'b1, 2'd0, 16'h00AA, 16'h0, 16'h0, 3'd4, 3'd7, 3'd2, "pc_pos_r7", 16'h3005, 16'h8001, 3'b001, 1'b0);

    // No bypass: R4 still 00AA while 0055 is being committed.
    cyc(1'b1, 1'b1, 2'd0, 16'h0055, 16'h0, 16'h0, 3'd4, 3'd4, 3'd4, "no_bypass_before", 16'h00AA, 16'h00AA, 3'b001, 1'b0);

    // Hold for 5 cycles.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b0, 2'd0, 16'hFFFF, 16'h0, 16'h0, 3'd1, 3'd4, 3'd1, "hold", 16'h0055, 16'h0, 3'b001, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd1, 3'd4, "hold_r1", 16'h0, 16'h0055, 3'b001, 1'b0);

    // Illegal select.
    cyc(1'b1, 1'b1, 2'd0, 16'h0011, 16'h0, 16'h0, 3'd0, 3'd0, 3'd1, "set_r0", 16'h0, 16'h0, 3'b001, 1'b0);
    cyc(1'b1, 1'b1, 2'd3, 16'hFFFF, 16'h0, 16'h8000, 3'd0, 3'd0, 3'd7, "illegal_issue", 16'h0011, 16'h3005, 3'b001, 1'b0);

    // Back-to-back commits to R6 with dual read.
    cyc(1'b1, 1'b1, 2'd0, 16'h0001, 16'h0, 16'h0, 3'd6, 3'd0, 3'd6, "illegal_after", 16'h0011, 16'h0, 3'b001, 1'b1);
    cyc(1'b1, 1'b1, 2'd0, 16'hFFFE, 16'h0, 16'h0, 3'd6, 3'd6, 3'd6, "b2b_first", 16'h0001, 16'h0001, 3'b001, 1'b1);
    cyc(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd6, 3'd6, "b2b_last_wins", 16'hFFFE, 16'hFFFE, 3'b100, 1'b1);

    // Sweep all registers: write phase reading R0, then read-back.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, 2'd0, sweep_val(i), 16'h0, 16'h0, 3'(i), 3'd0, 3'd0, "sweep_wr",
          (i == 0) ? 16'h0011 : sweep_val(0), (i == 0) ? 16'h0011 : sweep_val(0),
          (i == 0) ? 3'b100 : (sweep_val(i - 1)[15] ? 3'b100 : 3'b001), 1'b1);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'(i), 3'(7 - i), "sweep_rd",
          sweep_val(i), sweep_val(7 - i), 3'b100, 1'b1);

    // Mid-run reset with a commit pending.
    cyc(1'b1, 1'b1, 2'd0, 16'h1234, 16'h0, 16'h0, 3'd3, 3'd3, 3'd3, "set_r3", 16'h435A, 16'h435A, 3'b100, 1'b1);
    cyc(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd3, 3'd3, 3'd3, "r3_before_rst", 16'h1234, 16'h1234, 3'b001, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 16'h7777, 16'h0, 16'h0, 3'd3, 3'd3, 3'd3, "rst_immediate", 16'h0, 16'h0, 3'b000, 1'b0);
    cyc(1'b1, 1'b1, 2'd0, 16'h0000, 16'h0, 16'h0, 3'd1, 3'd3, 3'd7, "pending_lost", 16'h0, 16'h0, 3'b000, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd3, 3'd1, "first_commit", 16'h0, 16'h0, 3'b010, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
